// File: rtl/rv32i_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package rv32i_pkg;

  // Arbiter sequencing: IDLE arbitrates, REQ presents the command, RESP waits for the ack.
  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } arb_state_t;

  // Which requester owns the single outstanding transaction.
  typedef enum logic {
    OwnIf,
    OwnDm
  } arb_owner_t;

  localparam int unsigned ARB_STARVE_MAX_DEF = 4;
  localparam int unsigned ARB_STARVE_CNT_W   = 3;

  // Command as latched when leaving IDLE and replayed on the memory port.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } arb_cmd_t;

  // Instruction fetches are always full-word reads.
  function automatic arb_cmd_t arb_fetch_cmd(input logic [31:0] addr);
    arb_cmd_t cmd;
    cmd.we    = 1'b0;
    cmd.be    = 4'hF;
    cmd.addr  = addr;
    cmd.wdata = 32'h0;
    return cmd;
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data-side wins while an instruction fetch is waiting.
module arb_starve_cnt
  import rv32i_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        inc_i,
  input  logic                        clr_i,
  output logic [ARB_STARVE_CNT_W-1:0] cnt_o
);

  logic [ARB_STARVE_CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// One transaction in flight; data side has priority. Defining ARB_STARVE_GUARD_EN
// adds a starvation guard that forces a fetch after STARVE_MAX consecutive data wins.
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // Instruction fetch side
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  // Data side
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_valid_o,
  // Shared memory port
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  // Pipeline stalls
  output logic        stall_if_o,
  output logic        stall_mem_o
);

  arb_state_t state_q;
  arb_owner_t owner_q;
  arb_cmd_t   cmd_q;

  logic       arb_go;
  logic       fetch_force;
  logic       resp_done;
  arb_owner_t sel_owner;
  arb_cmd_t   sel_cmd;

  // Arbitration only happens from IDLE, which also gives the bubble after each completion.
  assign arb_go = (state_q == StIdle) && (if_req_i || dm_req_i);

`ifdef ARB_STARVE_GUARD_EN
  logic [ARB_STARVE_CNT_W-1:0] starve_cnt;
  logic                        starve_inc;
  logic                        starve_clr;

  assign fetch_force = if_req_i && (starve_cnt == ARB_STARVE_CNT_W'(STARVE_MAX));
  assign starve_inc  = arb_go && (sel_owner == OwnDm) && if_req_i;
  assign starve_clr  = arb_go && (sel_owner == OwnIf);

  arb_starve_cnt u_starve_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (starve_inc),
    .clr_i (starve_clr),
    .cnt_o (starve_cnt)
  );
`else
  logic unused_starve_max;

  assign fetch_force       = 1'b0;
  assign unused_starve_max = ^STARVE_MAX;
`endif

  // Pick the winner and the command it would present if arbitration fires this cycle.
  always_comb begin
    sel_owner = (fetch_force || !dm_req_i) ? OwnIf : OwnDm;
    if (sel_owner == OwnIf) begin
      sel_cmd = arb_fetch_cmd(if_addr_i);
    end else begin
      sel_cmd = '{we: dm_we_i, be: dm_be_i, addr: dm_addr_i, wdata: dm_wdata_i};
    end
  end

  // Transaction sequencer: latch owner/command on leaving IDLE, wait for gnt, then rvalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      owner_q <= OwnDm;
      cmd_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_go) begin
            state_q <= StReq;
            owner_q <= sel_owner;
            cmd_q   <= sel_cmd;
          end
        end
        StReq: begin
          if (mem_gnt_i) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          if (mem_rvalid_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_req_o   = (state_q == StReq);
  assign mem_we_o    = cmd_q.we;
  assign mem_be_o    = cmd_q.be;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;

  // Responses outside RESP are stray (e.g. from a transaction abandoned by reset).
  assign resp_done  = (state_q == StResp) && mem_rvalid_i;
  assign if_valid_o = resp_done && (owner_q == OwnIf);
  assign dm_valid_o = resp_done && (owner_q == OwnDm);
  assign if_rdata_o = if_valid_o ? mem_rdata_i : 32'h0;
  assign dm_rdata_o = dm_valid_o ? mem_rdata_i : 32'h0;

  assign stall_if_o  = if_req_i && !if_valid_o;
  assign stall_mem_o = dm_req_i && !dm_valid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  import rv32i_pkg::*;

  localparam int unsigned StarveMax = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_valid_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        stall_if_o;
  logic        stall_mem_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .STARVE_MAX (StarveMax)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_rdata_o   (if_rdata_o),
    .if_valid_o   (if_valid_o),
    .dm_req_i     (dm_req_i),
    .dm_we_i      (dm_we_i),
    .dm_be_i      (dm_be_i),
    .dm_addr_i    (dm_addr_i),
    .dm_wdata_i   (dm_wdata_i),
    .dm_rdata_o   (dm_rdata_o),
    .dm_valid_o   (dm_valid_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .stall_if_o   (stall_if_o),
    .stall_mem_o  (stall_mem_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one outstanding transaction, its owner and command.
  bit          m_busy;
  bit          m_granted;
  bit          m_own_dm;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          m_starve;
  bit          last_if_v = 1'b0;
  bit          last_dm_v = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_busy    = 1'b0;
    m_granted = 1'b0;
    m_own_dm  = 1'b1;
    m_starve  = 0;
  endtask

  // Check one cycle's outputs against the model, then advance model and clock.
  // Entered shortly after a falling edge with this cycle's inputs already driven.
  task automatic step();
    bit exp_req, exp_if_v, exp_dm_v, fetch_wins;
    #1;
    exp_req = m_busy && !m_granted;
    check_eq("mem_req", 32'(mem_req_o), 32'(exp_req));
    if (exp_req) begin
      check_eq("mem_we", 32'(mem_we_o), 32'(m_we));
      check_eq("mem_be", 32'(mem_be_o), 32'(m_be));
      check_eq("mem_addr", mem_addr_o, m_addr);
      check_eq("mem_wdata", mem_wdata_o, m_wdata);
    end
    exp_if_v = m_busy && m_granted && mem_rvalid_i && !m_own_dm;
    exp_dm_v = m_busy && m_granted && mem_rvalid_i && m_own_dm;
    check_eq("if_valid", 32'(if_valid_o), 32'(exp_if_v));
    check_eq("dm_valid", 32'(dm_valid_o), 32'(exp_dm_v));
    if (exp_if_v) check_eq("if_rdata", if_rdata_o, mem_rdata_i);
    if (exp_dm_v) check_eq("dm_rdata", dm_rdata_o, mem_rdata_i);
    if (m_busy && m_own_dm) check_eq("if_rdata_nonowner", if_rdata_o, 32'h0);
    if (m_busy && !m_own_dm) check_eq("dm_rdata_nonowner", dm_rdata_o, 32'h0);
    check_eq("stall_if", 32'(stall_if_o), 32'(if_req_i && !exp_if_v));
    check_eq("stall_mem", 32'(stall_mem_o), 32'(dm_req_i && !exp_dm_v));
    last_if_v = exp_if_v;
    last_dm_v = exp_dm_v;

    if (m_busy) begin
      if (!m_granted) m_granted = mem_gnt_i;
      else if (mem_rvalid_i) m_busy = 1'b0;
    end else if (if_req_i || dm_req_i) begin
      fetch_wins = !dm_req_i || (GuardEn && if_req_i && (m_starve == StarveMax));
      m_busy     = 1'b1;
      m_granted  = 1'b0;
      m_own_dm   = !fetch_wins;
      if (fetch_wins) begin
        m_we     = 1'b0;
        m_be     = 4'hF;
        m_addr   = if_addr_i;
        m_wdata  = 32'h0;
        m_starve = 0;
      end else begin
        m_we    = dm_we_i;
        m_be    = dm_be_i;
        m_addr  = dm_addr_i;
        m_wdata = dm_wdata_i;
        if (if_req_i && (m_starve < 7)) m_starve++;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    if_req_i     = 1'b0;
    dm_req_i     = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset pulse within one low clock phase; checks outputs drop immediately.
  task automatic do_reset();
    #1 rst_i = 1'b1;
    #1;
    check_eq("rst_mem_req", 32'(mem_req_o), 32'h0);
    check_eq("rst_if_valid", 32'(if_valid_o), 32'h0);
    check_eq("rst_dm_valid", 32'(dm_valid_o), 32'h0);
    rst_i = 1'b0;
    model_clear();
  endtask

  initial begin
    int mreq_cnt;
    bit owners[$];

    rst_i        = 1'b1;
    if_req_i     = 1'b0;
    if_addr_i    = 32'h0;
    dm_req_i     = 1'b0;
    dm_we_i      = 1'b0;
    dm_be_i      = 4'h0;
    dm_addr_i    = 32'h0;
    dm_wdata_i   = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    model_clear();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check_eq("reset_mem_req", 32'(mem_req_o), 32'h0);
    check_eq("reset_if_valid", 32'(if_valid_o), 32'h0);
    check_eq("reset_dm_valid", 32'(dm_valid_o), 32'h0);
    check_eq("reset_mem_addr", mem_addr_o, 32'h0);
    check_eq("reset_mem_be", 32'(mem_be_o), 32'h0);
    rst_i = 1'b0;
    idle(2);

    // Minimum-latency fetch.
    if_req_i = 1'b1; if_addr_i = 32'h100;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0050_0093;
    #1 check_eq("f_c0_stall_if", 32'(stall_if_o), 32'h1);
    step();
    #1 check_eq("f_c1_mem_req", 32'(mem_req_o), 32'h1);
    check_eq("f_c1_addr", mem_addr_o, 32'h100);
    check_eq("f_c1_stall_if", 32'(stall_if_o), 32'h1);
    step();
    #1 check_eq("f_c2_if_valid", 32'(if_valid_o), 32'h1);
    check_eq("f_c2_if_rdata", if_rdata_o, 32'h0050_0093);
    step();
    idle(2);

    // Simultaneous requests: data first, bubble, then fetch.
    if_req_i = 1'b1; if_addr_i = 32'h300;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h2000; dm_wdata_i = 32'h0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_0001;
    step();
    #1 check_eq("both_c1_addr", mem_addr_o, 32'h2000);
    step();
    #1 check_eq("both_c2_dm_valid", 32'(dm_valid_o), 32'h1);
    check_eq("both_c2_stall_if", 32'(stall_if_o), 32'h1);
    step();
    dm_req_i = 1'b0;
    #1 check_eq("both_c3_bubble", 32'(mem_req_o), 32'h0);
    check_eq("both_c3_stall_if", 32'(stall_if_o), 32'h1);
    step();
    #1 check_eq("both_c4_fetch_addr", mem_addr_o, 32'h300);
    check_eq("both_c4_stall_if", 32'(stall_if_o), 32'h1);
    step();
    #1 check_eq("both_c5_if_valid", 32'(if_valid_o), 32'h1);
    step();
    idle(2);

    // Store with delayed grant.
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'b0011;
    dm_addr_i = 32'h44; dm_wdata_i = 32'hDEAD_BEEF;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    step();
    mreq_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      mem_gnt_i = (i == 3);
      if (mem_req_o) mreq_cnt++;
      step();
    end
    check_eq("store_mem_req_cycles", 32'(mreq_cnt), 32'd4);
    mem_gnt_i = 1'b0;
    #1 check_eq("store_no_early_valid", 32'(dm_valid_o), 32'h0);
    step();
    mem_rvalid_i = 1'b1;
    #1 check_eq("store_dm_valid", 32'(dm_valid_o), 32'h1);
    step();
    idle(2);

    // Continuous contention: record which side each memory command belongs to.
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h400;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h800;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    for (int i = 0; i < 45; i++) begin
      mem_rdata_i = $urandom;
      if (mem_req_o) owners.push_back(mem_addr_o == 32'h400);
      step();
    end
    check_eq("starve_tx_count", 32'(owners.size()), 32'd15);
    for (int k = 0; k < owners.size(); k++) begin
      check_eq($sformatf("starve_owner_%0d", k), 32'(owners[k]),
               32'(GuardEn && ((k % 5) == 4)));
    end
    idle(3);

    // Reset during RESP, then a stray response.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h10;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
    step();
    step();
    dm_req_i = 1'b0; mem_gnt_i = 1'b0;
    do_reset();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    #1 check_eq("rst_resp_dm_valid", 32'(dm_valid_o), 32'h0);
    check_eq("rst_resp_mem_req", 32'(mem_req_o), 32'h0);
    step();
    step();
    idle(2);

    // Fetch request dropped while awaiting the response.
    if_req_i = 1'b1; if_addr_i = 32'h500;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
    step();
    step();
    if_req_i = 1'b0; mem_gnt_i = 1'b0;
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hABCD_0033;
    #1 check_eq("drop_if_valid", 32'(if_valid_o), 32'h1);
    step();
    mem_rvalid_i = 1'b0;
    #1 check_eq("drop_no_new_req", 32'(mem_req_o), 32'h0);
    step();
    idle(2);

    // Random traffic with noisy gnt/rvalid and occasional resets.
    for (int c = 0; c < 800; c++) begin
      if (last_if_v) if_req_i = 1'b0;
      if (last_dm_v) dm_req_i = 1'b0;
      if (!if_req_i && ($urandom_range(0, 2) == 0)) begin
        if_req_i  = 1'b1;
        if_addr_i = $urandom;
      end
      if (!dm_req_i && ($urandom_range(0, 1) == 0)) begin
        dm_req_i   = 1'b1;
        dm_we_i    = 1'($urandom);
        dm_be_i    = 4'($urandom);
        dm_addr_i  = $urandom;
        dm_wdata_i = $urandom;
      end
      mem_gnt_i    = 1'($urandom);
      mem_rvalid_i = 1'($urandom);
      mem_rdata_i  = $urandom;
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        last_if_v = 1'b0;
        last_dm_v = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive data wins tolerated while fetch waits.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 if_req  in  1  fetch request, held until if_valid; if_addr  in  32  fetch word address.
REQ-005 if_rdata  out  32  fetch data; if_valid  out  1  fetch completion pulse.
REQ-006 dm_req  in  1  data request, held until dm_valid; dm_we  in  1  write; dm_be  in  4  byte enables; dm_addr  in  32; dm_wdata  in  32.
REQ-007 dm_rdata  out  32  load data; dm_valid  out  1  data completion pulse (loads and stores).
REQ-008 mem_req  out  1; mem_we  out  1; mem_be  out  4; mem_addr  out  32; mem_wdata  out  32  shared memory port command.
REQ-009 mem_gnt  in  1  command accepted; mem_rvalid  in  1  response/ack; mem_rdata  in  32  response data.
REQ-010 stall_if  out  1  freeze IF/ID; stall_mem  out  1  freeze MEM and earlier stages.

Function
REQ-011 States IDLE, REQ, RESP; exactly one transaction outstanding; owner register (OWN_IF/OWN_DM) is latched on leaving IDLE.
REQ-012 IDLE: if dm_req or if_req, select owner, latch command, go REQ next edge; data wins by default.
REQ-013 REQ: mem_req=1 with latched command; mem_gnt=1 -> RESP next edge; otherwise hold REQ with command stable.
REQ-014 RESP: mem_rvalid=1 -> owner's valid=1 that cycle, owner's rdata=mem_rdata combinationally, next state IDLE; otherwise hold RESP.
REQ-015 Minimum latency: request seen cycle 0 -> mem_req cycle 1 -> valid cycle 2 (gnt and rvalid immediate).
REQ-016 One IDLE bubble after every completion; no same-cycle re-arbitration (requester still holds req that cycle).
REQ-017 Fetch command: mem_we=0, mem_be=4'hF, mem_wdata=0.
REQ-018 stall_if = if_req and not if_valid; stall_mem = dm_req and not dm_valid; both combinational.
REQ-019 Requester dropping req mid-transaction: transaction completes, valid still pulses, no abort on the memory port.
REQ-020 mem_rvalid in IDLE or REQ ignored; mem_gnt outside REQ ignored.
REQ-021 Non-owner valid stays 0; non-owner rdata driven 0.

Reset
REQ-022 rst asserted at any time: state IDLE, owner OWN_DM, latched command 0, starvation count 0, mem_req=0, if_valid=dm_valid=0 asynchronously.
REQ-023 Transaction in flight at reset is abandoned; its late mem_rvalid is ignored per REQ-020.

Configuration
REQ-024 Macro ARB_STARVE_GUARD_EN defined: 3-bit saturating count increments when data wins while if_req=1, clears when fetch wins; at count==STARVE_MAX with if_req=1 fetch wins regardless of dm_req.
REQ-025 Macro undefined: strict data priority, no counter logic present.

Structure
REQ-026 rv32i_pkg gains arb_state_t (IDLE, REQ, RESP) and arb_owner_t (OWN_IF, OWN_DM) enums plus ARB_STARVE_MAX_DEF=4.
REQ-027 Starvation counter is sub-module arb_starve_cnt, instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-028 if_req=1, if_addr=0x100, gnt/rvalid immediate, mem_rdata=0x00500093 -> mem_req cycle 1, if_valid and if_rdata=0x00500093 cycle 2, stall_if 1 in cycles 0-1.
REQ-029 if_req and dm_req (load 0x2000) same cycle -> data served first, fetch issued after one IDLE bubble; stall_if high throughout.
REQ-030 dm store, dm_be=4'b0011, gnt delayed 3 cycles -> mem_req held 4 cycles with stable command, dm_valid on rvalid only.
REQ-031 Guard enabled, STARVE_MAX=4, dm_req and if_req continuously -> 4 data transactions then 1 fetch, repeating; guard disabled -> fetch never served.
REQ-032 rst pulsed in RESP, then mem_rvalid=1 -> no valid pulse, state IDLE, mem_req=0.
REQ-033 if_req dropped while in RESP -> if_valid still pulses on rvalid, next state IDLE, no new mem_req.
